// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit (lsu_rmw).
// Optional feature macro used by the LSU: LSU_ALIGN_CHECK_EN.
package lsu_pkg;

    localparam int LSU_N = 32;

    // bit3 = store, bit2 = unsigned load, bits[1:0] = size (00 byte, 01 half, 10 word)
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } op_ls_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } state_e;

    // True when the access size does not fit the byte offset.
    function automatic logic is_misaligned(op_ls_e op, logic [1:0] off);
        logic [1:0] sz;
        sz = op[1:0];
        case (sz)
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Clears the offset bits that a half/word access is not allowed to carry.
    function automatic logic [1:0] align_off(op_ls_e op, logic [1:0] off);
        logic [1:0] sz;
        sz = op[1:0];
        case (sz)
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// CPU-side request/response bundle of the load/store unit.
// Handshake: the master holds req with op/addr/wdata stable; the LSU
// accepts on a rising edge where req=1 and ready=1. done pulses for one
// cycle when the access finishes, with ld_data and err valid in that cycle.
interface lsu_rmw_if;
    import lsu_pkg::*;

    logic             req;
    op_ls_e           op_ls;
    logic [31:0]      addr;
    logic [LSU_N-1:0] wdata;
    logic             ready;
    logic             done;
    logic [LSU_N-1:0] ld_data;
    logic             err;

    modport master (
        output req, op_ls, addr, wdata,
        input  ready, done, ld_data, err
    );

    modport slave (
        input  req, op_ls, addr, wdata,
        output ready, done, ld_data, err
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte/half lane logic: extracts and extends a load lane from the memory
// word, and inserts sub-word store data into the memory word for RMW.
module lsu_lane (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load lane select plus sign/zero extension.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = rdata_i;
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (size_i)
            2'b00:   ld_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            2'b01:   ld_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: ld_data_o = rdata_i;
        endcase
    end

    // Store lane insert into the word read back from memory.
    always_comb begin
        merged_o = rdata_i;
        case (size_i)
            2'b00: begin
                case (off_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            2'b01: begin
                if (off_i[1]) merged_o[31:16] = wdata_i;
                else          merged_o[15:0]  = wdata_i;
            end
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests
// into accesses on a word-wide memory without byte enables; sub-word stores
// take an extra read-modify-write cycle.
// Optional macro LSU_ALIGN_CHECK_EN: flag misaligned half/word accesses via
// err (no memory write); when undefined, offending offset bits are cleared.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    lsu_rmw_if.slave          cpu,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LSU_N-1:0]  mem_st_data_o,
    output logic              mem_st_en_o,
    input  logic [LSU_N-1:0]  mem_ld_data_i,
    output state_e            state_o
);

    state_e            state_q;
    op_ls_e            op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [LSU_N-1:0]  st_data_q;
    logic              st_en_q;
    logic [LSU_N-1:0]  ld_data_q;
    logic              done_q;
    logic              err_q;
    logic              ready_q;
    logic              misalign_q;

    logic [1:0]        off_d;
    logic              misalign_d;
    logic [LSU_N-1:0]  lane_ld;
    logic [LSU_N-1:0]  lane_merged;
    logic              unused_addr;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_d = is_misaligned(cpu.op_ls, cpu.addr[1:0]);
    assign off_d      = cpu.addr[1:0];
`else
    assign misalign_d = 1'b0;
    assign off_d      = align_off(cpu.op_ls, cpu.addr[1:0]);
`endif

    // Address bits above the memory window wrap and are not stored.
    assign unused_addr = ^cpu.addr[31:ADDR_W+2];

    lsu_lane u_lane (
        .size_i     (op_q[1:0]),
        .unsigned_i (op_q[2]),
        .off_i      (addr_q[1:0]),
        .rdata_i    (mem_ld_data_i),
        .wdata_i    (wdata_q),
        .ld_data_o  (lane_ld),
        .merged_o   (lane_merged)
    );

    // Access FSM with registered handshake and memory strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            st_data_q  <= '0;
            st_en_q    <= 1'b0;
            ld_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            st_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.req) begin
                        op_q       <= cpu.op_ls;
                        addr_q     <= {cpu.addr[ADDR_W+1:2], off_d};
                        wdata_q    <= cpu.wdata[15:0];
                        st_data_q  <= cpu.wdata;
                        misalign_q <= misalign_d;
                        // Word stores write in ACCESS, so the strobe is armed now.
                        st_en_q    <= cpu.op_ls[3] & cpu.op_ls[1] & ~misalign_d;
                        ready_q    <= 1'b0;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (misalign_q) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (!op_q[3]) begin
                        ld_data_q <= lane_ld;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else if (op_q[1]) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        st_data_q <= lane_merged;
                        st_en_q   <= 1'b1;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu.ready     = ready_q;
    assign cpu.done      = done_q;
    assign cpu.ld_data   = ld_data_q;
    assign cpu.err       = err_q;
    assign mem_addr_o    = addr_q[ADDR_W+1:2];
    assign mem_st_data_o = st_data_q;
    // Reset blocks the write at the very edge it is sampled.
    assign mem_st_en_o   = st_en_q & rst_ni;
    assign state_o       = state_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word memory model and a done-driven scoreboard.
module tb_lsu_rmw;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [31:0] ld;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  mem_addr;
    logic [31:0] mem_st_data;
    logic        mem_st_en;
    logic [31:0] mem_ld_data;
    state_e      dbg_state;
    logic [31:0] mem [1024];
    int          cyc;
    int          total;
    int          bad;
    exp_t        exp_q[$];
    logic [31:0] last_ld;

    lsu_rmw_if bus ();

    lsu_rmw #(.ADDR_W(10)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cpu           (bus),
        .mem_addr_o    (mem_addr),
        .mem_st_data_o (mem_st_data),
        .mem_st_en_o   (mem_st_en),
        .mem_ld_data_i (mem_ld_data),
        .state_o       (dbg_state)
    );

    // clock / cycle counter / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_st_en) mem[mem_addr] <= mem_st_data;
    assign mem_ld_data = mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("ld_data", bus.ld_data, e.ld);
                check("err", {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    end

    // Driver: called at a negedge; returns at the negedge of the done cycle.
    task automatic issue(op_ls_e op, logic [31:0] addr, logic [31:0] wdata,
                         logic [31:0] exp_ld, logic exp_err, logic [31:0] exp_wr,
                         output int t_acc);
        int   n;
        int   lat;
        logic exp_st;
        exp_t e;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        t_acc = 0;
        if (bus.ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.req   = 1'b1;
        bus.op_ls = op;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        #1;
        t_acc   = cyc;
        bus.req = 1'b0;
        lat    = (op[3] && !op[1] && !exp_err) ? 3 : 2;
        exp_st = op[3] && op[1] && !exp_err;
        e.cyc  = t_acc + lat - 1;
        e.err  = exp_err;
        e.ld   = exp_ld;
        exp_q.push_back(e);
        @(negedge clk);
        check("access_st_en", {31'd0, mem_st_en}, {31'd0, exp_st});
        check("mem_addr", {22'd0, mem_addr}, {22'd0, addr[11:2]});
        if (exp_st) check("sw_st_data", mem_st_data, exp_wr);
        @(negedge clk);
        if (lat == 3) begin
            check("write_st_en", {31'd0, mem_st_en}, 32'd1);
            check("rmw_st_data", mem_st_data, exp_wr);
            @(negedge clk);
        end
    endtask

    task automatic do_load(op_ls_e op, logic [31:0] addr, logic [31:0] exp_ld, output int t);
        issue(op, addr, 32'h0, exp_ld, 1'b0, 32'h0, t);
        last_ld = exp_ld;
    endtask

    task automatic do_store(op_ls_e op, logic [31:0] addr, logic [31:0] wdata, logic [31:0] exp_wr);
        int t;
        issue(op, addr, wdata, last_ld, 1'b0, exp_wr, t);
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        int n;
        cyc       = 0;
        total     = 0;
        bad       = 0;
        last_ld   = 32'h0;
        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.op_ls = LB;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        check("rst_st_en", {31'd0, mem_st_en}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // word store, then loads on every lane/extension
        do_store(SW, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        check("mem4_sw", mem[4], 32'hDEADBEEF);
        do_load(LB,  32'h13, 32'hFFFFFFDE, t);
        do_load(LBU, 32'h13, 32'h000000DE, t);
        do_load(LH,  32'h10, 32'hFFFFBEEF, t);
        do_load(LHU, 32'h12, 32'h0000DEAD, t);
        do_load(LB,  32'h11, 32'hFFFFFFBE, t);
        do_load(LW,  32'h10, 32'hDEADBEEF, t);

        // sub-word stores via read-modify-write
        do_store(SB, 32'h11, 32'h00000055, 32'hDEAD55EF);
        check("mem4_sb", mem[4], 32'hDEAD55EF);
        do_store(SH, 32'h12, 32'h00001234, 32'h123455EF);
        check("mem4_sh", mem[4], 32'h123455EF);

        // misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
        issue(LW, 32'h12, 32'h0, last_ld, 1'b1, 32'h0, t);
`else
        do_load(LW, 32'h12, 32'h123455EF, t);
`endif
        check("mem4_after_lw12", mem[4], 32'h123455EF);

        // reset during the WRITE cycle of an SB
        do_store(SW, 32'h14, 32'hA5A5A5A5, 32'hA5A5A5A5);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req   = 1'b1;
        bus.op_ls = SB;
        bus.addr  = 32'h14;
        bus.wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_state", 32'(dbg_state), 32'(WRITE));
        rst_n = 1'b0;
        #1;
        check("rst_mid_st_en", {31'd0, mem_st_en}, 32'd0);
        @(negedge clk);
        check("rst_mid_mem5", mem[5], 32'hA5A5A5A5);
        check("rst_mid_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_mid_idle", 32'(dbg_state), 32'(IDLE));
        check("rst_mid_ld", bus.ld_data, 32'h0);
        last_ld = 32'h0;
        rst_n   = 1'b1;

        // address wrap beyond the memory window
        do_store(SW, 32'h1010, 32'h0BADF00D, 32'h0BADF00D);
        check("mem4_wrap", mem[4], 32'h0BADF00D);

        // back-to-back loads
        do_load(LW, 32'h10, 32'h0BADF00D, t1);
        do_load(LW, 32'h14, 32'hA5A5A5A5, t2);
        check("b2b_accept", t2, t1 + 2);
        do_load(LH,  32'h16, 32'hFFFFA5A5, t);
        do_load(LBU, 32'h17, 32'h000000A5, t);

        // misaligned half store
`ifdef LSU_ALIGN_CHECK_EN
        issue(SH, 32'h11, 32'hCAFE, last_ld, 1'b1, 32'h0, t);
        check("mem4_sh11", mem[4], 32'h0BADF00D);
`else
        do_store(SH, 32'h11, 32'h0000CAFE, 32'h0BADCAFE);
        check("mem4_sh11", mem[4], 32'h0BADCAFE);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
